// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// No logic here; the state encoding is 3 bits so it fits the seven loader states.
// Optional feature elsewhere: BOOT_CHECKSUM_EN adds the trailing CHK byte state.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/boot_word_packer.sv
// Packs four little-endian stream bytes into one 32-bit word.
// Latency: word_out/word_done are combinational on the 4th byte_en (0 cycles).
// Backpressure: none; accepts a byte every cycle that byte_en is high, clear wins.
module boot_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  input  logic        clear,
  output logic [31:0] word_out,
  output logic        word_done
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;

  // The first three bytes sit in acc_q; the 4th byte completes the word on the wire.
  assign word_out  = {byte_in, acc_q};
  assign word_done = byte_en && !clear && (lane_q == 2'd3);

  // Next lane and shift register: bytes enter from the top so byte 0 ends up in [7:0].
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (clear) begin
      lane_d = 2'd0;
      acc_d  = '0;
    end else if (byte_en) begin
      lane_d = lane_q + 2'd1;
      acc_d  = {byte_in, acc_q[23:8]};
    end
  end

  // Lane counter and assemble register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= 2'd0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream (A5, LEN_LO, LEN_HI, LEN words LE) into instruction memory, holds core in reset until done.
// Latency: memory write strobe 1 cycle after the 4th byte of a word; completion outputs update on the same edge.
// Backpressure: never stalls; rx_ready is high in every state except RUN. Macro BOOT_CHECKSUM_EN adds a trailing CHK byte.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam logic [31:0]       CAPACITY = 32'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t FRAME_END = CHK;
`else
  localparam boot_state_t FRAME_END = RUN;
`endif

  boot_state_t       state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [15:0]       word_idx_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              core_reset_q;
  logic              done_q;
  logic              error_q;

  logic        accept;
  logic        is_sync;
  logic        resync;
  logic [15:0] len_in;
  logic        last_word;
  logic [31:0] word_out;
  logic        word_done;

  assign rx_ready   = (state_q != RUN);
  assign accept     = rx_valid && rx_ready;
  assign is_sync    = (rx_data == SYNC_BYTE);
  assign resync     = accept && is_sync && ((state_q == IDLE) || (state_q == ERR));
  assign len_in     = {rx_data, len_lo_q};
  assign last_word  = (word_idx_q == (len_q - 16'd1));

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

  boot_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (rx_data),
    .byte_en   (accept && (state_q == DATA)),
    .clear     (resync),
    .word_out  (word_out),
    .word_done (word_done)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running 8-bit sum over the length bytes and every data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= 8'd0;
    end else if (accept) begin
      if (state_q == LEN_LO) begin
        sum_q <= rx_data;
      end else if ((state_q == LEN_HI) || (state_q == DATA)) begin
        sum_q <= sum_q + rx_data;
      end
    end
  end
`endif

  // Frame FSM: sync hunt, length capture, data packing, optional checksum, then park in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_sync) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if (32'(len_in) > CAPACITY) begin
            state_d = ERR;
          end else if (len_in == 16'd0) begin
            state_d = FRAME_END;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_done && last_word) state_d = FRAME_END;
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (rx_data == sum_q) ? RUN : ERR;
      end
`endif
      RUN: begin
        state_d = RUN;
      end
      ERR: begin
        if (accept && is_sync) state_d = LEN_LO;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, length/word counters and registered outputs; status flags follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= 8'd0;
      len_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_A;
      wr_data_q    <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= (state_d != RUN);
      done_q       <= (state_d == RUN);
      error_q      <= (state_d == ERR);
      wr_en_q      <= word_done;
      if (accept && (state_q == LEN_LO)) len_lo_q <= rx_data;
      if (accept && (state_q == LEN_HI)) len_q <= len_in;
      if (resync) begin
        word_idx_q <= 16'd0;
      end else if (word_done) begin
        word_idx_q <= word_idx_q + 16'd1;
      end
      if (word_done) begin
        wr_addr_q <= BASE_A + ADDR_W'(word_idx_q);
        wr_data_q <= word_out;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (ADDR_W=4, BASE_ADDR=0).
// Table of frames with expected writes/status, plus hand sequences for mid-frame reset and a full-capacity burst.
// Works with or without BOOT_CHECKSUM_EN defined.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_reset;
  logic        done;
  logic        error;

  imem_boot_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][7:0] bytes;
    logic [4:0]       nb;
    logic [3:0][31:0] words;
    logic [2:0]       nw;
    logic             exp_done;
    logic             exp_error;
  } vec_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  localparam int NVEC = 7;
  vec_t vecs [0:NVEC-1];
  wr_t  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int cyc      = 0;
  int last_wr_cyc = -1;
  logic spacing_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {28'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
        chk("wr_data", wr_data, e.data);
      end
      if (spacing_en && last_wr_cyc >= 0) chk("wr_spacing", cyc - last_wr_cyc, 4);
      last_wr_cyc = cyc;
    end
  end

  task automatic load(input int k, input int n, input logic [127:0] lit);
    vecs[k] = '0;
    for (int i = 0; i < n; i++) vecs[k].bytes[i] = lit[(n-1-i)*8 +: 8];
    vecs[k].nb = 5'(n);
  endtask

  task automatic add_byte(input int k, input logic [7:0] b);
    vecs[k].bytes[vecs[k].nb] = b;
    vecs[k].nb = vecs[k].nb + 5'd1;
  endtask

  task automatic add_word(input int k, input logic [31:0] w);
    vecs[k].words[vecs[k].nw] = w;
    vecs[k].nw = vecs[k].nw + 3'd1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_count = 0;
    last_wr_cyc = -1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] w;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;

    // Frame table.
    load(0, 11, 88'hA5_02_00_13_00_00_00_93_00_10_00);
    add_word(0, 32'h0000_0013); add_word(0, 32'h0010_0093);
    vecs[0].exp_done = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    add_byte(0, 8'hB8);
`endif
    load(1, 10, 80'h00_FF_12_A5_01_00_EF_BE_AD_DE);
    add_word(1, 32'hDEAD_BEEF);
    vecs[1].exp_done = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    add_byte(1, 8'h39);
`endif
    load(2, 3, 24'hA5_11_00);
    vecs[2].exp_error = 1'b1;
    load(3, 6, 48'hA5_11_00_A5_00_00);
    vecs[3].exp_done = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    add_byte(3, 8'h00);
`endif
    load(4, 7, 56'hA5_01_00_01_02_03_04);
    add_word(4, 32'h0403_0201);
    vecs[4].exp_done = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    add_byte(4, 8'h0B);
`endif
    // With checksum the trailing 0C is a bad CHK; without, it arrives in RUN and is ignored.
    load(5, 8, 64'hA5_01_00_01_02_03_04_0C);
    add_word(5, 32'h0403_0201);
`ifdef BOOT_CHECKSUM_EN
    vecs[5].exp_error = 1'b1;
`else
    vecs[5].exp_done = 1'b1;
`endif
    load(6, 12, 96'hA5_11_00_33_44_A5_01_00_AA_BB_CC_DD);
    add_word(6, 32'hDDCC_BBAA);
    vecs[6].exp_done = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    add_byte(6, 8'h0F);
`endif

    for (int k = 0; k < NVEC; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      do_reset();
      for (int i = 0; i < int'(vecs[k].nw); i++) exp_q.push_back('{addr: 4'(i), data: vecs[k].words[i]});
      for (int i = 0; i < int'(vecs[k].nb); i++) send(vecs[k].bytes[i]);
      settle();
      chk({tag, "_done"}, {31'd0, done}, {31'd0, vecs[k].exp_done});
      chk({tag, "_error"}, {31'd0, error}, {31'd0, vecs[k].exp_error});
      chk({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !vecs[k].exp_done});
      chk({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, !vecs[k].exp_done});
      chk({tag, "_write_count"}, wr_count, {29'd0, vecs[k].nw});
      chk({tag, "_pending_writes"}, exp_q.size(), 0);
      exp_q.delete();
    end

    // Reset in the middle of a 3-word frame, then resend the whole frame.
    do_reset();
    exp_q.push_back('{addr: 4'd0, data: 32'h4433_2211});
    send(8'hA5); send(8'h03); send(8'h00);
    for (int i = 1; i <= 6; i++) send(8'(i * 17));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    chk("midreset_pending_writes", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'((4*i + j + 1) * 17);
      exp_q.push_back('{addr: 4'(i), data: w});
    end
    sum = 8'h03;
    send(8'hA5); send(8'h03); send(8'h00);
    for (int i = 1; i <= 12; i++) begin
      b = 8'(i * 17);
      sum = sum + b;
      send(b);
    end
`ifdef BOOT_CHECKSUM_EN
    send(sum);
`endif
    settle();
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_pending_writes", exp_q.size(), 0);

    // Full-capacity frame (LEN == 16) streamed back-to-back, then inert RUN.
    do_reset();
    spacing_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(4*i + j + 8'h40);
      exp_q.push_back('{addr: 4'(i), data: w});
    end
    sum = 8'h10;
    send(8'hA5); send(8'h10); send(8'h00);
    for (int i = 0; i < 64; i++) begin
      b = 8'(i + 8'h40);
      sum = sum + b;
      send(b);
    end
`ifndef BOOT_CHECKSUM_EN
    rx_valid = 1'b0;
    @(negedge clk);
    chk("last_write_with_release_wr_en", {31'd0, wr_en}, 32'd1);
    chk("last_write_with_release_done", {31'd0, done}, 32'd1);
    chk("last_write_with_release_core_reset", {31'd0, core_reset}, 32'd0);
`else
    send(sum);
`endif
    settle();
    spacing_en = 1'b0;
    chk("cap_done", {31'd0, done}, 32'd1);
    chk("cap_pending_writes", exp_q.size(), 0);
    chk("cap_write_count", wr_count, 16);
    chk("run_rx_ready", {31'd0, rx_ready}, 32'd0);
    for (int i = 0; i < 4; i++) send(8'hA5);
    settle();
    chk("run_stays_done", {31'd0, done}, 32'd1);
    chk("run_no_error", {31'd0, error}, 32'd0);
    chk("run_wr_addr_static", {28'd0, wr_addr}, 32'd15);
    chk("run_write_count", wr_count, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
